// File: rtl/bp_be_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_be_pkg
//  Description : Shared constants, helpers and types for the issue queue.
//  Revision    : 1.0  initial release
// ============================================================================
package bp_be_pkg;

    // Default entry count of the issue queue
    localparam int BP_BE_IQ_ELS = 8;

    // Pointer width for an els-entry queue: index bits plus one wrap bit
    function automatic int bp_be_ptr_width(input int els);
        return $clog2(els) + 1;
    endfunction

    localparam int BP_BE_IQ_PTR_W = bp_be_ptr_width(BP_BE_IQ_ELS);

    // Queue pointer for the default configuration: {wrap, index}
    typedef logic [BP_BE_IQ_PTR_W-1:0] bp_be_iq_ptr_t;

endpackage
`default_nettype wire

// File: rtl/bsg_mem_1r1w.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_mem_1r1w
//  Description : One-write, one-read register-file storage. Synchronous
//                write, asynchronous read, contents not reset.
//  Revision    : 1.0  initial release
// ============================================================================
module bsg_mem_1r1w #(
    parameter int width_p = 64,
    parameter int els_p   = 8
) (
    input  logic                       clk_i,
    input  logic                       w_v_i,
    input  logic [$clog2(els_p)-1:0]   w_addr_i,
    input  logic [width_p-1:0]         w_data_i,
    input  logic [$clog2(els_p)-1:0]   r_addr_i,
    output logic [width_p-1:0]         r_data_o
);

    logic [width_p-1:0] r_mem [els_p];

    // Write port: capture payload on the rising edge when enabled
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            r_mem[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = r_mem[r_addr_i];

endmodule
`default_nettype wire

// File: rtl/bp_be_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : bp_be_issue_queue
//  Description : Replayable issue queue with separate write, speculative-read
//                and commit pointers. Entries stay in storage until committed
//                with deq_i, so roll_i can rewind reads to the oldest
//                uncommitted entry. clr_i discards everything.
//  Config      : define BP_BE_ISSUE_QUEUE_BYPASS_EN to forward an enqueue to
//                the read port in the same cycle when no unread entry exists.
//  Revision    : 1.0  initial release
// ============================================================================
module bp_be_issue_queue
    import bp_be_pkg::*;
#(
    parameter int els_p   = 8,
    parameter int width_p = 64
) (
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic [width_p-1:0]         data_i,
    input  logic                       v_i,
    output logic                       ready_o,

    output logic [width_p-1:0]         data_o,
    output logic                       v_o,
    input  logic                       yumi_i,

    input  logic                       deq_i,
    input  logic                       roll_i,
    input  logic                       clr_i,

    output logic [$clog2(els_p+1)-1:0] count_o
);

    localparam int LG_ELS = $clog2(els_p);
    localparam int PTR_W  = bp_be_ptr_width(els_p);
    localparam int CNT_W  = $clog2(els_p + 1);

    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [PTR_W-1:0]   r_cptr;
    logic [PTR_W-1:0]   w_wptr_n;
    logic [PTR_W-1:0]   w_rptr_n;
    logic [PTR_W-1:0]   w_cptr_n;

    logic               w_full;
    logic               w_rd_empty;
    logic               w_enq;
    logic [width_p-1:0] w_mem_data;

    // Full when write and commit point at the same slot on different laps;
    // depends only on state so ready_o has no input path.
    assign w_full     = (r_wptr[LG_ELS-1:0] == r_cptr[LG_ELS-1:0]) &&
                        (r_wptr[LG_ELS] != r_cptr[LG_ELS]);
    assign ready_o    = ~w_full;
    assign w_rd_empty = (r_rptr == r_wptr);
    assign w_enq      = v_i & ready_o & ~clr_i;

    // Pointer next-state: clear wins; roll uses the post-deq commit point
    always_comb begin
        w_wptr_n = r_wptr;
        w_rptr_n = r_rptr;
        w_cptr_n = r_cptr;
        if (clr_i) begin
            w_wptr_n = '0;
            w_rptr_n = '0;
            w_cptr_n = '0;
        end else begin
            if (w_enq) begin
                w_wptr_n = r_wptr + PTR_W'(1);
            end
            if (deq_i) begin
                w_cptr_n = r_cptr + PTR_W'(1);
            end
            if (roll_i) begin
                w_rptr_n = w_cptr_n;
            end else if (yumi_i) begin
                w_rptr_n = r_rptr + PTR_W'(1);
            end
        end
    end

    // Pointer registers with asynchronous reset
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cptr <= '0;
        end else begin
            r_wptr <= w_wptr_n;
            r_rptr <= w_rptr_n;
            r_cptr <= w_cptr_n;
        end
    end

    bsg_mem_1r1w #(
        .width_p (width_p),
        .els_p   (els_p)
    ) u_mem (
        .clk_i    (clk_i),
        .w_v_i    (w_enq),
        .w_addr_i (r_wptr[LG_ELS-1:0]),
        .w_data_i (data_i),
        .r_addr_i (r_rptr[LG_ELS-1:0]),
        .r_data_o (w_mem_data)
    );

`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
    logic w_bypass;

    // Forward the incoming entry when nothing unread is stored; it is still
    // written, and a same-cycle yumi advances rptr alongside wptr.
    assign w_bypass = w_rd_empty & w_enq;
    assign v_o      = ~w_rd_empty | w_bypass;
    assign data_o   = w_bypass ? data_i : w_mem_data;
`else
    assign v_o      = ~w_rd_empty;
    assign data_o   = w_mem_data;
`endif

    // Occupancy from commit boundary to write point, modulo 2*els_p
    assign count_o = CNT_W'(r_wptr - r_cptr);

    a_yumi_needs_valid: assert property (
        @(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

    a_deq_needs_read: assert property (
        @(posedge clk_i) disable iff (reset_i) deq_i |-> (r_cptr != r_rptr));

endmodule
`default_nettype wire

// File: tb/tb_bp_be_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bp_be_issue_queue
//  Description : Self-checking bench for bp_be_issue_queue (els_p=8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bp_be_issue_queue;

    localparam int ELS = 8;
    localparam int W   = 64;
    localparam int CW  = $clog2(ELS + 1);

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [W-1:0]  data_i;
    logic          v_i;
    logic          ready_o;
    logic [W-1:0]  data_o;
    logic          v_o;
    logic          yumi_i;
    logic          deq_i;
    logic          roll_i;
    logic          clr_i;
    logic [CW-1:0] count_o;

    int errors = 0;
    int checks = 0;

    bp_be_issue_queue #(.els_p(ELS), .width_p(W)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (data_i),
        .v_i     (v_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .v_o     (v_o),
        .yumi_i  (yumi_i),
        .deq_i   (deq_i),
        .roll_i  (roll_i),
        .clr_i   (clr_i),
        .count_o (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          v;
        logic          yumi;
        logic          deq;
        logic          roll;
        logic          clr;
        logic [W-1:0]  data;
        logic          ev;
        logic          er;
        logic [CW-1:0] ec;
        logic [W-1:0]  ed;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        v_i = 1'b0; yumi_i = 1'b0; deq_i = 1'b0; roll_i = 1'b0; clr_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Behavioural model: q holds uncommitted entries oldest first,
    // rd is how many of them have been read speculatively.
    logic [W-1:0] q [$];
    int           rd;

    localparam logic [W-1:0] A = 64'hAAAA_0000_0000_0001;
    localparam logic [W-1:0] B = 64'hBBBB_0000_0000_0002;
    localparam logic [W-1:0] C = 64'hCCCC_0000_0000_0003;

    initial begin
        reset_i = 1'b1;
        data_i  = '0;
        idle();
        #1;
        chk("reset_ready", ready_o, 1);
        chk("reset_v",     v_o,     0);
        chk("reset_count", count_o, 0);
        tick();
        tick();
        reset_i = 1'b0;

        // Replay scenario: each row is one cycle; outputs checked afterwards
        //            v  yumi deq roll clr data    ev er ec  ed
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, A, 1'b1,1'b1,4'd1, A};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, B, 1'b1,1'b1,4'd2, A};
        tbl[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, C, 1'b1,1'b1,4'd3, A};
        tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 0, 1'b1,1'b1,4'd3, B};
        tbl[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 0, 1'b1,1'b1,4'd3, C};
        tbl[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 0, 1'b1,1'b1,4'd2, C};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 0, 1'b1,1'b1,4'd2, B};
        tbl[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 0, 1'b1,1'b1,4'd2, C};
        tbl[8]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 0, 1'b1,1'b1,4'd1, C};
        tbl[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 0, 1'b0,1'b1,4'd1, 0};
        tbl[10] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 0, 1'b0,1'b1,4'd0, 0};

        for (int i = 0; i < 11; i++) begin
            v_i = tbl[i].v; yumi_i = tbl[i].yumi; deq_i = tbl[i].deq;
            roll_i = tbl[i].roll; clr_i = tbl[i].clr; data_i = tbl[i].data;
            tick();
            idle();
            #1;
            chk($sformatf("tbl%0d_v", i),     v_o,     tbl[i].ev);
            chk($sformatf("tbl%0d_ready", i), ready_o, tbl[i].er);
            chk($sformatf("tbl%0d_count", i), count_o, tbl[i].ec);
            if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), data_o, tbl[i].ed);
        end

        // Fill to capacity; a ninth enqueue is refused
        clr_i = 1'b1; tick(); idle();
        for (int i = 0; i < ELS; i++) begin
            v_i = 1'b1; data_i = W'(i); tick();
        end
        idle(); #1;
        chk("fill_ready", ready_o, 0);
        chk("fill_count", count_o, 8);
        v_i = 1'b1; data_i = 64'd99; tick(); idle(); #1;
        chk("fill_9th_count", count_o, 8);
        chk("fill_9th_head",  data_o,  0);
        // Full with enqueue and commit together: ready was low, so no enqueue
        yumi_i = 1'b1; tick(); idle();
        v_i = 1'b1; deq_i = 1'b1; data_i = 64'd77; tick(); idle(); #1;
        chk("full_enq_deq_count", count_o, 7);
        chk("full_enq_deq_ready", ready_o, 1);
        chk("full_enq_deq_data",  data_o,  1);

        // Clear takes priority over everything else in its cycle
        clr_i = 1'b1; tick(); idle();
        for (int i = 0; i < 5; i++) begin
            v_i = 1'b1; data_i = W'(100 + i); tick();
        end
        idle();
        yumi_i = 1'b1; tick(); idle();
        v_i = 1'b1; yumi_i = 1'b1; deq_i = 1'b1; clr_i = 1'b1; data_i = 64'd5;
        tick(); idle(); #1;
        chk("clr_v",     v_o,     0);
        chk("clr_count", count_o, 0);
        chk("clr_ready", ready_o, 1);

        // Wrap: enqueue / read / commit triples across pointer wraps
        for (int i = 0; i < 20; i++) begin
            v_i = 1'b1; data_i = {48'hC0DE_0000_0000, 16'(i)}; tick(); idle(); #1;
            chk($sformatf("wrap%0d_count", i), count_o, 1);
            yumi_i = 1'b1; #1;
            chk($sformatf("wrap%0d_v", i),    v_o,    1);
            chk($sformatf("wrap%0d_data", i), data_o, {48'hC0DE_0000_0000, 16'(i)});
            tick(); idle();
            deq_i = 1'b1; tick(); idle();
        end
        #1;
        chk("wrap_end_count", count_o, 0);

`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
        // Same-cycle forward of an enqueue into an empty queue
        v_i = 1'b1; data_i = 64'hDEAD; yumi_i = 1'b1; #1;
        chk("byp_v",    v_o,    1);
        chk("byp_data", data_o, 64'hDEAD);
        tick(); idle(); #1;
        chk("byp_next_v",     v_o,     0);
        chk("byp_next_count", count_o, 1);
        deq_i = 1'b1; tick(); idle(); #1;
        chk("byp_deq_count", count_o, 0);
`else
        // Without forwarding the entry appears one cycle after the handshake
        v_i = 1'b1; data_i = 64'hDEAD; #1;
        chk("nobyp_v_same", v_o, 0);
        tick(); idle(); #1;
        chk("nobyp_v_next",  v_o,     1);
        chk("nobyp_data",    data_o,  64'hDEAD);
        chk("nobyp_count",   count_o, 1);
        yumi_i = 1'b1; tick(); idle();
        deq_i = 1'b1; tick(); idle(); #1;
        chk("nobyp_deq_count", count_o, 0);
`endif

        // Asynchronous reset in the middle of an enqueue burst
        for (int i = 0; i < 3; i++) begin
            v_i = 1'b1; data_i = W'(200 + i); tick();
        end
        #2;
        reset_i = 1'b1;
        #1;
        chk("async_rst_ready", ready_o, 1);
        chk("async_rst_v",     v_o,     0);
        chk("async_rst_count", count_o, 0);
        tick();
        idle();
        reset_i = 1'b0;

        // Randomized traffic against the behavioural model
        q.delete();
        rd = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic         r_clr, r_vi, r_yumi, r_deq, r_roll, enq_ok, byp, mv;
            logic [W-1:0] d;
            r_clr  = ($urandom % 64) == 0;
            r_vi   = ($urandom % 2) == 0;
            d      = {$urandom, $urandom};
            enq_ok = r_vi && (q.size() < ELS) && !r_clr;
            byp    = 1'b0;
`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
            byp    = (rd == q.size()) && enq_ok;
`endif
            mv     = (rd < q.size()) || byp;
            r_yumi = mv && (($urandom % 2) == 0);
            r_deq  = (rd > 0) && (($urandom % 3) == 0);
            r_roll = ($urandom % 8) == 0;

            v_i = r_vi; data_i = d; yumi_i = r_yumi; deq_i = r_deq;
            roll_i = r_roll; clr_i = r_clr;
            #1;
            chk("rnd_ready", ready_o, q.size() < ELS);
            chk("rnd_count", count_o, q.size());
            chk("rnd_v",     v_o,     mv);
            if (mv) chk("rnd_data", data_o, (rd < q.size()) ? q[rd] : d);
            tick();

            if (r_clr) begin
                q.delete();
                rd = 0;
            end else begin
                if (r_deq) begin
                    void'(q.pop_front());
                    rd--;
                end
                if (r_roll) rd = 0;
                else if (r_yumi) rd++;
                if (enq_ok) q.push_back(d);
            end
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
